// File: rtl/axi_lite_regs_pkg.sv
// axi_lite_regs_pkg: AXI-Lite response codes shared by the register blocks
package axi_lite_regs_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
endpackage

// File: rtl/axi_lite_regs.sv
// axi_lite_regs: AXI-Lite register file with control output and read-only status word
module axi_lite_regs
  import axi_lite_regs_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 8,
  parameter int AXI_DATA_WIDTH = 16,
  parameter int NUM_REGS       = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [AXI_ADDR_WIDTH-1:0] axi_awaddr,
  input  logic                      axi_awvalid,
  output logic                      axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0] axi_wdata,
  input  logic                      axi_wstrb,
  input  logic                      axi_wvalid,
  output logic                      axi_wready,
  output logic [1:0]                axi_bresp,
  output logic                      axi_bvalid,
  input  logic                      axi_bready,
  input  logic [AXI_ADDR_WIDTH-1:0] axi_araddr,
  input  logic                      axi_arvalid,
  output logic                      axi_arready,
  output logic [AXI_DATA_WIDTH-1:0] axi_rdata,
  output logic [1:0]                axi_rresp,
  output logic                      axi_rvalid,
  input  logic                      axi_rready,
  output logic [AXI_DATA_WIDTH-1:0] ctrl_out,
  input  logic [AXI_DATA_WIDTH-1:0] status_in
);
  localparam logic W_IDLE = 1'b0, W_RESP = 1'b1;
  localparam logic R_IDLE = 1'b0, R_RESP = 1'b1;
  localparam int IW = $clog2(NUM_REGS);
  // index of the status word; anything below it is a writable register
  localparam logic [AXI_ADDR_WIDTH:0] LAST = (AXI_ADDR_WIDTH+1)'(NUM_REGS - 1);
  logic [AXI_DATA_WIDTH-1:0] regs [NUM_REGS];
  logic                      w_state, r_state, aw_held, w_held, wstrb_q;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr;
  logic [AXI_DATA_WIDTH-1:0] wdata_q;
  logic                      aw_ok, ar_ok, ar_status;
  assign axi_awready = (w_state == W_IDLE) && !aw_held;
  assign axi_wready  = (w_state == W_IDLE) && !w_held;
  assign axi_arready = (r_state == R_IDLE);
  assign aw_ok       = {1'b0, aw_addr} < LAST;
  assign ar_ok       = {1'b0, axi_araddr} < LAST;
  assign ar_status   = {1'b0, axi_araddr} == LAST;
  assign ctrl_out    = regs[0];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_state    <= W_IDLE;
      aw_held    <= 1'b0;
      w_held     <= 1'b0;
      aw_addr    <= '0;
      wdata_q    <= '0;
      wstrb_q    <= 1'b0;
      axi_bvalid <= 1'b0;
      axi_bresp  <= RESP_OKAY;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      if (axi_awvalid && axi_awready) begin
        aw_addr <= axi_awaddr;
        aw_held <= 1'b1;
      end
      if (axi_wvalid && axi_wready) begin
        wdata_q <= axi_wdata;
        wstrb_q <= axi_wstrb;
        w_held  <= 1'b1;
      end
      if (w_state == W_IDLE && aw_held && w_held) begin
        w_state    <= W_RESP;
        axi_bvalid <= 1'b1;
        axi_bresp  <= aw_ok ? RESP_OKAY : RESP_SLVERR;
        if (aw_ok && wstrb_q) regs[aw_addr[IW-1:0]] <= wdata_q;
      end
      if (w_state == W_RESP && axi_bready) begin
        w_state    <= W_IDLE;
        axi_bvalid <= 1'b0;
        aw_held    <= 1'b0;
        w_held     <= 1'b0;
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= R_IDLE;
      axi_rvalid <= 1'b0;
      axi_rdata  <= '0;
      axi_rresp  <= RESP_OKAY;
    end else if (axi_arvalid && axi_arready) begin
      r_state    <= R_RESP;
      axi_rvalid <= 1'b1;
      axi_rdata  <= ar_ok ? regs[axi_araddr[IW-1:0]] : ar_status ? status_in : '0;
      axi_rresp  <= (ar_ok || ar_status) ? RESP_OKAY : RESP_SLVERR;
    end else if (r_state == R_RESP && axi_rready) begin
      r_state    <= R_IDLE;
      axi_rvalid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_axi_lite_regs.sv
// tb_axi_lite_regs: directed scoreboard bench for the AXI-Lite register block
module tb_axi_lite_regs;
  import axi_lite_regs_pkg::*;
  typedef struct packed {logic [15:0] d; logic [1:0] r;} rexp_t;
  logic        clk = 0, reset = 1;
  logic [7:0]  axi_awaddr = 0, axi_araddr = 0;
  logic        axi_awvalid = 0, axi_wvalid = 0, axi_wstrb = 0, axi_bready = 0;
  logic        axi_arvalid = 0, axi_rready = 0;
  logic [15:0] axi_wdata = 0, status_in = 0;
  logic        axi_awready, axi_wready, axi_bvalid, axi_arready, axi_rvalid;
  logic [1:0]  axi_bresp, axi_rresp;
  logic [15:0] axi_rdata, ctrl_out;
  logic [15:0] mdl [16];
  logic [1:0]  b_q [$];
  rexp_t       r_q [$];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  axi_lite_regs dut (
    .clk(clk), .reset(reset),
    .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .ctrl_out(ctrl_out), .status_in(status_in)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic rexp_t rd_model(input logic [7:0] a);
    rexp_t e;
    e.d = a < 15 ? mdl[a[3:0]] : a == 15 ? status_in : 16'h0;
    e.r = a <= 15 ? RESP_OKAY : RESP_SLVERR;
    return e;
  endfunction
  task automatic push_wr(input logic [7:0] a, input logic [15:0] d, input logic s);
    b_q.push_back(a < 15 ? RESP_OKAY : RESP_SLVERR);
    if (a < 15 && s) mdl[a[3:0]] = d;
  endtask
  task automatic wait_b();
    int n = 0;
    while (!axi_bvalid && n < 20) begin tick(); n++; end
    chk("b_timeout", axi_bvalid, 1);
  endtask
  task automatic wait_r();
    int n = 0;
    while (!axi_rvalid && n < 20) begin tick(); n++; end
    chk("r_timeout", axi_rvalid, 1);
  endtask
  task automatic take_b(input string tag);
    logic [1:0] e;
    wait_b();
    e = b_q.pop_front();
    chk(tag, axi_bresp, e);
    axi_bready = 1;
    tick();
    axi_bready = 0;
  endtask
  task automatic take_r(input string tag);
    rexp_t e;
    wait_r();
    e = r_q.pop_front();
    chk({tag, "_data"}, axi_rdata, e.d);
    chk({tag, "_resp"}, axi_rresp, e.r);
    axi_rready = 1;
    tick();
    axi_rready = 0;
  endtask
  task automatic do_write(input logic [7:0] a, input logic [15:0] d, input logic s);
    push_wr(a, d, s);
    axi_awaddr = a; axi_wdata = d; axi_wstrb = s;
    axi_awvalid = 1; axi_wvalid = 1;
    tick();
    axi_awvalid = 0; axi_wvalid = 0;
    take_b($sformatf("bresp_a%0d", a));
  endtask
  task automatic do_read(input logic [7:0] a);
    r_q.push_back(rd_model(a));
    axi_araddr = a; axi_arvalid = 1;
    tick();
    axi_arvalid = 0;
    take_r($sformatf("rd_a%0d", a));
  endtask
  initial begin
    rexp_t held;
    logic [1:0] bq;
    for (int i = 0; i < 16; i++) mdl[i] = 0;
    tick(); tick();
    chk("rst_bvalid", axi_bvalid, 0);
    chk("rst_rvalid", axi_rvalid, 0);
    chk("rst_ctrl", ctrl_out, 0);
    chk("rst_rdata", axi_rdata, 0);
    chk("rst_resp", {axi_bresp, axi_rresp}, 0);
    chk("rst_readies", {axi_awready, axi_wready, axi_arready}, 3'b111);
    reset = 0;
    tick();
    do_write(3, 16'hA5A5, 1);
    do_read(3);
    // W three cycles ahead of AW
    push_wr(0, 16'h1234, 1);
    axi_wdata = 16'h1234; axi_wstrb = 1; axi_wvalid = 1;
    tick();
    axi_wvalid = 0;
    for (int i = 0; i < 3; i++) begin
      chk("w_early_wready", axi_wready, 0);
      chk("w_early_bvalid", axi_bvalid, 0);
      tick();
    end
    axi_awaddr = 0; axi_awvalid = 1;
    tick();
    axi_awvalid = 0;
    chk("aw_late_bvalid_pre", axi_bvalid, 0);
    tick();
    chk("aw_late_bvalid", axi_bvalid, 1);
    chk("aw_late_ctrl", ctrl_out, 16'h1234);
    take_b("aw_late_bresp");
    status_in = 16'hBEEF;
    do_read(15);
    do_write(15, 16'h5A5A, 1);
    do_read(15);
    do_read(20);
    do_write(20, 16'hFFFF, 1);
    do_read(0);
    do_read(3);
    do_write(3, 16'h0F0F, 0);
    do_read(3);
    // stalled B and R
    push_wr(5, 16'h5555, 1);
    axi_awaddr = 5; axi_wdata = 16'h5555; axi_wstrb = 1; axi_awvalid = 1; axi_wvalid = 1;
    tick();
    axi_awvalid = 0; axi_wvalid = 0;
    wait_b();
    bq = b_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      chk("stall_bvalid", axi_bvalid, 1);
      chk("stall_bresp", axi_bresp, bq);
      chk("stall_readies", {axi_awready, axi_wready}, 2'b00);
      tick();
    end
    axi_bready = 1;
    tick();
    axi_bready = 0;
    chk("b_done", axi_bvalid, 0);
    chk("ready_after_b", {axi_awready, axi_wready}, 2'b11);
    held = rd_model(5);
    axi_araddr = 5; axi_arvalid = 1;
    tick();
    axi_arvalid = 0;
    for (int i = 0; i < 4; i++) begin
      chk("stall_rvalid", axi_rvalid, 1);
      chk("stall_rdata", axi_rdata, held.d);
      chk("stall_arready", axi_arready, 0);
      tick();
    end
    axi_rready = 1;
    tick();
    axi_rready = 0;
    // read handshake on the same edge as the write commit sees old data
    r_q.push_back(rd_model(6));
    push_wr(6, 16'h6666, 1);
    axi_awaddr = 6; axi_wdata = 16'h6666; axi_wstrb = 1; axi_awvalid = 1; axi_wvalid = 1;
    tick();
    axi_awvalid = 0; axi_wvalid = 0;
    axi_araddr = 6; axi_arvalid = 1;
    tick();
    axi_arvalid = 0;
    take_r("rw_same_edge");
    take_b("rw_same_edge_bresp");
    do_read(6);
    for (int i = 0; i < 6; i++) begin
      logic [7:0] a;
      a = 8'($urandom_range(0, 17));
      do_write(a, 16'($urandom), 1'($urandom_range(0, 1)));
      do_read(8'($urandom_range(0, 17)));
    end
    chk("ctrl_follows_r0", ctrl_out, mdl[0]);
    // reset while AW held and W still pending
    axi_awaddr = 7; axi_awvalid = 1;
    tick();
    axi_awvalid = 0; axi_wdata = 16'h7777; axi_wstrb = 1; axi_wvalid = 1;
    #1 reset = 1;
    for (int i = 0; i < 16; i++) mdl[i] = 0;
    tick(); tick();
    axi_wvalid = 0;
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      chk("abort_bvalid", axi_bvalid, 0);
      chk("abort_readies", {axi_awready, axi_wready, axi_arready}, 3'b111);
      tick();
    end
    do_read(7);
    chk("abort_ctrl", ctrl_out, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
